// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory-address sequencer: source select codes,
// sequencer states, default exception vectors and an alignment helper.
package mem_seq_pkg;

  localparam logic [2:0] SRC_PC     = 3'd0;
  localparam logic [2:0] SRC_ALUOUT = 3'd1;
  localparam logic [2:0] SRC_VEC0   = 3'd2;
  localparam logic [2:0] SRC_ALURES = 3'd3;
  localparam logic [2:0] SRC_VEC1   = 3'd4;

  localparam int unsigned VEC0_DEF = 252;
  localparam int unsigned VEC1_DEF = 253;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } seq_state_e;

  // BEATS is a power of two, so the low bits decide alignment.
  function automatic logic is_misaligned(input logic [31:0] addr, input int unsigned beats);
    return (addr & (beats - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/mem_src_mux.sv
// Address source selector: resolves src_sel to an ADDR_W-bit address and
// flags illegal codes and exception-vector sources.
module mem_src_mux
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned VEC0   = VEC0_DEF,
  parameter int unsigned VEC1   = VEC1_DEF
) (
  input  logic [2:0]        src_sel_i,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       alu_out_i,
  input  logic [31:0]       alu_result_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              illegal_o,
  output logic              is_vector_o
);

  logic [31:0] sel_full_s;
  logic        unused_sel_bits_s;

  // Pick the full 32-bit source; vectors are constants.
  always_comb begin
    sel_full_s  = 32'd0;
    illegal_o   = 1'b0;
    is_vector_o = 1'b0;
    case (src_sel_i)
      SRC_PC:     sel_full_s = pc_i;
      SRC_ALUOUT: sel_full_s = alu_out_i;
      SRC_ALURES: sel_full_s = alu_result_i;
      SRC_VEC0: begin
        sel_full_s  = 32'(VEC0);
        is_vector_o = 1'b1;
      end
      SRC_VEC1: begin
        sel_full_s  = 32'(VEC1);
        is_vector_o = 1'b1;
      end
      default:    illegal_o = 1'b1;
    endcase
  end

  assign addr_o            = sel_full_s[ADDR_W-1:0];
  assign unused_sel_bits_s = ^sel_full_s;

endmodule

// File: rtl/mem_addr_seq.sv
// Multi-beat memory address sequencer: latches a base from the selected source
// and walks base+0 .. base+BEATS-1 with MEM_LAT wait cycles per beat.
module mem_addr_seq
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BEATS     = 4,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned VEC0      = VEC0_DEF,
  parameter int unsigned VEC1      = VEC1_DEF,
  parameter int unsigned ALIGN_CHK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        src_sel,
  input  logic [31:0]       pc_output,
  input  logic [31:0]       alu_out_output,
  input  logic [31:0]       alu_result,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              beat_valid,
  output logic [3:0]        beat_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 32'd1);
  localparam logic [2:0] LAT_C     = 3'(MEM_LAT);

  seq_state_e        state_q, state_d;
  logic [3:0]        beat_q, beat_d;
  logic [2:0]        lat_q, lat_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic [ADDR_W-1:0] src_addr_s;
  logic              src_illegal_s, src_is_vec_s, reject_s, active_d_s;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        beat_idx_q, beat_idx_d;
  logic              mem_rd_q, mem_rd_d, beat_valid_q, beat_valid_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  mem_src_mux #(
    .ADDR_W (ADDR_W),
    .VEC0   (VEC0),
    .VEC1   (VEC1)
  ) u_src_mux (
    .src_sel_i    (src_sel),
    .pc_i         (pc_output),
    .alu_out_i    (alu_out_output),
    .alu_result_i (alu_result),
    .addr_o       (src_addr_s),
    .illegal_o    (src_illegal_s),
    .is_vector_o  (src_is_vec_s)
  );

  // Vectors are exempt from the alignment rule.
  assign reject_s = src_illegal_s ||
                    ((ALIGN_CHK != 32'd0) && !src_is_vec_s &&
                     is_misaligned(32'(src_addr_s), BEATS));

  // Next-state logic for the sequencer FSM and its counters.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        if (!start) begin
          state_d = IDLE;
        end else if (reject_s) begin
          state_d = ERR;
        end else begin
          base_d  = src_addr_s;
          beat_d  = 4'd0;
          lat_d   = 3'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (MEM_LAT != 32'd0) begin
          state_d = WAIT;
          lat_d   = 3'd1;
        end else if (beat_q == LAST_BEAT) begin
          state_d = DONE;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      WAIT: begin
        if (lat_q != LAT_C) begin
          lat_d = lat_q + 3'd1;
        end else if (beat_q == LAST_BEAT) begin
          lat_d   = 3'd0;
          state_d = DONE;
        end else begin
          lat_d   = 3'd0;
          beat_d  = beat_q + 4'd1;
          state_d = ISSUE;
        end
      end
      DONE, ERR: begin
        state_d = IDLE;
        beat_d  = 4'd0;
        lat_d   = 3'd0;
      end
      default: begin
        state_d = IDLE;
        beat_d  = 4'd0;
        lat_d   = 3'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered.
  always_comb begin
    active_d_s   = (state_d == ISSUE) || (state_d == WAIT);
    mem_addr_d   = active_d_s ? (base_d + ADDR_W'(beat_d)) : {ADDR_W{1'b0}};
    beat_idx_d   = active_d_s ? beat_d : 4'd0;
    mem_rd_d     = (state_d == ISSUE);
    beat_valid_d = ((state_d == ISSUE) && (MEM_LAT == 32'd0)) ||
                   ((state_d == WAIT) && (lat_d == LAT_C));
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    err_d        = (state_d == ERR);
  end

  // State, counters, base and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= 4'd0;
      lat_q        <= 3'd0;
      base_q       <= {ADDR_W{1'b0}};
      mem_addr_q   <= {ADDR_W{1'b0}};
      beat_idx_q   <= 4'd0;
      mem_rd_q     <= 1'b0;
      beat_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      lat_q        <= lat_d;
      base_q       <= base_d;
      mem_addr_q   <= mem_addr_d;
      beat_idx_q   <= beat_idx_d;
      mem_rd_q     <= mem_rd_d;
      beat_valid_q <= beat_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign beat_valid = beat_valid_q;
  assign beat_idx   = beat_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Scoreboard bench for mem_addr_seq: default instance (BEATS=4, MEM_LAT=1) and
// a fast instance (BEATS=2, MEM_LAT=0), checked every cycle.
module tb_mem_addr_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [2:0]  src_sel;
  logic [31:0] pc_output, alu_out_output, alu_result;

  logic [7:0] a_mem_addr, b_mem_addr;
  logic       a_mem_rd, a_beat_valid, a_busy, a_done, a_err;
  logic       b_mem_rd, b_beat_valid, b_busy, b_done, b_err;
  logic [3:0] a_beat_idx, b_beat_idx;

  always #5 clk = ~clk;

  mem_addr_seq u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .src_sel(src_sel),
    .pc_output(pc_output), .alu_out_output(alu_out_output), .alu_result(alu_result),
    .mem_addr(a_mem_addr), .mem_rd(a_mem_rd), .beat_valid(a_beat_valid),
    .beat_idx(a_beat_idx), .busy(a_busy), .done(a_done), .err(a_err)
  );

  mem_addr_seq #(.BEATS(2), .MEM_LAT(0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .src_sel(src_sel),
    .pc_output(pc_output), .alu_out_output(alu_out_output), .alu_result(alu_result),
    .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .beat_valid(b_beat_valid),
    .beat_idx(b_beat_idx), .busy(b_busy), .done(b_done), .err(b_err)
  );

  // Observed word: {addr, rd, valid, idx, busy, done, err}
  logic [16:0] obs_a, obs_b;
  assign obs_a = {a_mem_addr, a_mem_rd, a_beat_valid, a_beat_idx, a_busy, a_done, a_err};
  assign obs_b = {b_mem_addr, b_mem_rd, b_beat_valid, b_beat_idx, b_busy, b_done, b_err};

  localparam logic [16:0] ERR_W = {8'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};

  logic [16:0] q_a[$];
  logic [16:0] q_b[$];
  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  // Expected word for cycle k (1-based) after the start edge of a good access.
  function automatic logic [16:0] exp_word(input logic [7:0] base, input int beats,
                                           input int lat, input int k);
    int p, n, b, ph;
    logic [7:0] a;
    p = lat + 1;
    n = beats * p;
    if (k <= n) begin
      b  = (k - 1) / p;
      ph = (k - 1) % p;
      a  = base + 8'(b);
      return {a, (ph == 0), (ph == lat), 4'(b), 1'b1, 1'b0, 1'b0};
    end
    return {8'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
  endfunction

  task automatic push_a(input logic [7:0] base);
    for (int k = 1; k <= 9; k++) q_a.push_back(exp_word(base, 4, 1, k));
  endtask

  task automatic push_b(input logic [7:0] base);
    for (int k = 1; k <= 3; k++) q_b.push_back(exp_word(base, 2, 0, k));
  endtask

  // One cycle: sample at the falling edge and compare both DUTs.
  task automatic step();
    logic [16:0] ea, eb;
    @(negedge clk);
    cyc++;
    ea = (q_a.size() > 0) ? q_a.pop_front() : 17'd0;
    eb = (q_b.size() > 0) ? q_b.pop_front() : 17'd0;
    check_val($sformatf("A_c%0d", cyc), 32'(obs_a), 32'(ea));
    check_val($sformatf("B_c%0d", cyc), 32'(obs_b), 32'(eb));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic launch_a(input logic [2:0] sel, input logic [7:0] base, input bit bad);
    src_sel = sel;
    if (bad) q_a.push_back(ERR_W);
    else     push_a(base);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    src_sel = 3'd5;
    while (q_a.size() > 0) step();
    idle(2);
  endtask

  task automatic launch_b(input logic [2:0] sel, input logic [7:0] base, input bit bad);
    src_sel = sel;
    if (bad) q_b.push_back(ERR_W);
    else     push_b(base);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    src_sel = 3'd6;
    while (q_b.size() > 0) step();
    idle(2);
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; src_sel = 3'd0;
    pc_output = 32'd0; alu_out_output = 32'd0; alu_result = 32'd0;
    idle(2);
    reset = 1'b0;
    idle(2);

    pc_output = 32'h40;
    launch_a(3'd0, 8'h40, 1'b0);
    launch_a(3'd2, 8'd252, 1'b0);
    launch_a(3'd4, 8'd253, 1'b0);
    alu_out_output = 32'h0000_0102;
    launch_a(3'd1, 8'd0, 1'b1);
    launch_a(3'd6, 8'd0, 1'b1);
    launch_a(3'd5, 8'd0, 1'b1);
    alu_result = 32'h1234_5678;
    launch_a(3'd3, 8'h78, 1'b0);
    alu_out_output = 32'hABCD_0020;
    launch_a(3'd1, 8'h20, 1'b0);

    alu_result = 32'h10;
    launch_b(3'd3, 8'h10, 1'b0);
    alu_result = 32'h11;
    launch_b(3'd3, 8'd0, 1'b1);
    launch_b(3'd4, 8'd253, 1'b0);

    // Start held high: second access begins in cycle 11 with the new PC.
    pc_output = 32'h40;
    src_sel   = 3'd0;
    push_a(8'h40);
    q_a.push_back(17'd0);
    push_a(8'h80);
    start_a = 1'b1;
    step();
    pc_output = 32'h80;
    repeat (10) step();
    start_a = 1'b0;
    while (q_a.size() > 0) step();
    idle(2);

    // Reset during cycle 4 of an access.
    pc_output = 32'h40;
    src_sel   = 3'd0;
    push_a(8'h40);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    idle(2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_mid_A", 32'(obs_a), 32'd0);
    q_a.delete();
    idle(2);
    reset = 1'b0;
    idle(12);
    launch_a(3'd0, 8'h40, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
